// File: rtl/mul_share_arb_if.sv
// Requester, response and multiplier-port bundle for mul_share_arb.
// Operand vectors are packed per requester: requester i occupies [i][W-1:0].
interface mul_share_arb_if #(
  parameter int N = 4,
  parameter int W = 4
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  logic [N-1:0][W-1:0]   req_a;
  logic [N-1:0][W-1:0]   req_b;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [2*W-1:0]        rsp_data;
  logic [N-1:0]          busy;
  logic [W-1:0]          mul_a;
  logic [W-1:0]          mul_b;
  logic [2*W-1:0]        mul_out;

  modport master (
    output req_valid, req_a, req_b, mul_out,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy, mul_a, mul_b
  );

  modport slave (
    input  req_valid, req_a, req_b, mul_out,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy, mul_a, mul_b
  );
endinterface

// File: rtl/mul_share_arb.sv
// Round-robin sharing of one LAT-deep pipelined multiplier among N requesters,
// with a tag pipeline carrying the issuing requester ID alongside each product.
module mul_share_arb_lane (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic set,
  input  logic clr,
  output logic busy,
  output logic elig
);
  // set and clr are mutually exclusive: set needs ~busy, clr needs busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      busy <= 1'b0;
    else if (set) busy <= 1'b1;
    else if (clr) busy <= 1'b0;
  end

  assign elig = req_valid & ~busy;
endmodule

module mul_share_arb #(
  parameter int N   = 4,
  parameter int W   = 4,
  parameter int LAT = 2,
  localparam int IDW = $clog2(N)
) (
  input logic           clk,
  input logic           rst,
  mul_share_arb_if.slave bus
);
  logic [N-1:0]         elig;
  logic [N-1:0]         busy_q;
  logic [N-1:0]         grant_raw;
  logic [N-1:0]         grant;
  logic [N-1:0]         done_oh;
  logic [IDW-1:0]       gnt_id;
  logic [IDW-1:0]       idx;
  logic                 found;
  logic                 issue;

  logic [IDW-1:0]       ptr;
  logic [LAT:0]         vld_pipe;
  logic [LAT:0][IDW-1:0] id_pipe;
  logic [W-1:0]         mul_a_q;
  logic [W-1:0]         mul_b_q;
  logic                 rsp_valid_q;
  logic [IDW-1:0]       rsp_id_q;
  logic [2*W-1:0]       rsp_data_q;

  mul_share_arb_lane u_lane [N-1:0] (
    .clk       (clk),
    .rst       (rst),
    .req_valid (bus.req_valid),
    .set       (grant),
    .clr       (done_oh),
    .busy      (busy_q),
    .elig      (elig)
  );

  // First eligible requester at or after ptr, wrapping modulo N
  always_comb begin
    grant_raw = '0;
    gnt_id    = '0;
    idx       = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = IDW'((int'(ptr) + k) % N);
      if (!found && elig[idx]) begin
        found          = 1'b1;
        grant_raw[idx] = 1'b1;
        gnt_id         = idx;
      end
    end
  end

  assign grant   = rst ? '0 : grant_raw;
  assign issue   = |grant;
  assign done_oh = vld_pipe[LAT] ? (N'(1) << id_pipe[LAT]) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      vld_pipe    <= '0;
      id_pipe     <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[LAT-1:0], issue};
      id_pipe     <= {id_pipe[LAT-1:0], gnt_id};
      rsp_valid_q <= vld_pipe[LAT];
      if (vld_pipe[LAT]) begin
        rsp_id_q   <= id_pipe[LAT];
        rsp_data_q <= bus.mul_out;
      end
      if (issue) begin
        mul_a_q <= bus.req_a[gnt_id];
        mul_b_q <= bus.req_b[gnt_id];
        ptr     <= (gnt_id == IDW'(N-1)) ? '0 : gnt_id + IDW'(1);
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.busy      = busy_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_mul_share_arb.sv
// Scoreboard bench for mul_share_arb: cycle-level reference model predicts grants,
// busy and operand registers; a monitor pops expected responses on rsp_valid.
module tb_mul_share_arb;
  localparam int N   = 4;
  localparam int W   = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_share_arb_if #(.N(N), .W(W)) bus ();

  mul_share_arb #(.N(N), .W(W), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural multiplier, LAT edges from mul_a/mul_b to mul_out, never reset
  logic [2*W-1:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= bus.mul_a * bus.mul_b;
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.mul_out = mpipe[LAT-1];

  typedef struct {
    int id;
    int data;
    int due;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   cyc      = 0;
  int   ptr_m    = 0;
  int   busy_until [N];
  int   last_a   = 0;
  int   last_b   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: per-requester busy windows in absolute cycles, RR pointer as an int
  logic [N-1:0] eb, er;
  int g, idx;
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data,
                            bus.busy, bus.mul_a, bus.mul_b}, 64'd0);
      ptr_m  = 0;
      last_a = 0;
      last_b = 0;
      for (int i = 0; i < N; i++) busy_until[i] = 0;
      q.delete();
    end else begin
      eb = '0;
      er = '0;
      g  = -1;
      for (int i = 0; i < N; i++) eb[i] = (cyc < busy_until[i]);
      for (int k = 0; k < N; k++) begin
        idx = (ptr_m + k) % N;
        if (g < 0 && bus.req_valid[idx] && !eb[idx]) g = idx;
      end
      if (g >= 0) er[g] = 1'b1;
      chk("busy", bus.busy, eb);
      chk("req_ready", bus.req_ready, er);
      chk("mul_a", bus.mul_a, last_a);
      chk("mul_b", bus.mul_b, last_b);
      if (g >= 0) begin
        q.push_back('{g, int'(bus.req_a[g]) * int'(bus.req_b[g]), cyc + LAT + 2});
        busy_until[g] = cyc + LAT + 2;
        ptr_m  = (g + 1) % N;
        last_a = int'(bus.req_a[g]);
        last_b = int'(bus.req_b[g]);
      end
    end
  end

  // Monitor: every rsp_valid pulse must match the oldest outstanding issue
  exp_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rsp_valid) begin
        if (q.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 0);
        else begin
          e = q.pop_front();
          chk("rsp_id", bus.rsp_id, e.id);
          chk("rsp_data", bus.rsp_data, e.data);
          chk("rsp_time", cyc, e.due);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        chk("rsp_missing", bus.rsp_valid, 1);
        void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Requesters in mask hold req_valid until their own handshake
  task automatic hold_until_granted(input logic [N-1:0] m);
    logic [N-1:0] f;
    bus.req_valid = m;
    for (int c = 0; c < 40 && bus.req_valid != '0; c++) begin
      @(negedge clk);
      f = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      bus.req_valid = bus.req_valid & ~f;
    end
    chk("grant_timeout", bus.req_valid, 0);
    bus.req_valid = '0;
  endtask

  task automatic drain();
    for (int c = 0; c < 60 && q.size() != 0; c++) tick();
    chk("drain", q.size(), 0);
    tick();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;

    // Reset held with random requests, then release with a random nonzero set
    repeat (4) begin
      bus.req_valid = N'($urandom);
      bus.req_a     = (N*W)'($urandom);
      bus.req_b     = (N*W)'($urandom);
      tick();
    end
    bus.req_valid = N'($urandom_range(1, (1 << N) - 1));
    rst = 1'b0;
    tick();
    bus.req_valid = '0;
    drain();

    // Single op on requester 0
    do_reset();
    bus.req_a[0] = 4'hA;
    bus.req_b[0] = 4'hA;
    hold_until_granted(4'b0001);
    drain();

    // Full contention from ptr 0
    do_reset();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i] = W'(i + 1);
      bus.req_b[i] = 4'hF;
    end
    hold_until_granted(4'b1111);
    drain();

    // Requester 2 held valid: re-issues every LAT+2 cycles
    bus.req_a[2]  = 4'd3;
    bus.req_b[2]  = 4'd5;
    bus.req_valid = 4'b0100;
    repeat (3 * (LAT + 2) + 1) tick();
    bus.req_valid = '0;
    drain();

    // Reset one cycle after issue discards the in-flight op; reissue afterwards
    bus.req_a[1] = 4'hD;
    bus.req_b[1] = 4'h8;
    hold_until_granted(4'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    hold_until_granted(4'b0010);
    drain();

    // Fairness between 1 and 3 starting from ptr 2
    do_reset();
    bus.req_a[1] = 4'h1;
    bus.req_b[1] = 4'h1;
    hold_until_granted(4'b0010);
    drain();
    bus.req_a[1]  = 4'h7;
    bus.req_b[1]  = 4'h9;
    bus.req_a[3]  = 4'hE;
    bus.req_b[3]  = 4'hB;
    bus.req_valid = 4'b1010;
    repeat (12) tick();
    bus.req_valid = '0;
    drain();

    // Random traffic with occasional reset pulses
    repeat (400) begin
      bus.req_valid = N'($urandom);
      bus.req_a     = (N*W)'($urandom);
      bus.req_b     = (N*W)'($urandom);
      rst           = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst           = 1'b0;
    bus.req_valid = '0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/mul_share_arb.md
# mul_share_arb

Round-robin arbiter and sequencer that lets up to N requesters share one pipelined unsigned multiplier (the `pipeline_mul` datapath). Each requester hands over operands with a valid/ready handshake. The block issues at most one operation per cycle into the multiplier and tracks each in-flight operation's requester ID through a tag pipeline matched to the multiplier latency. It returns every product with the ID of the requester that issued it, and allows at most one outstanding operation per requester.

## Interface
- N, 4, number of requesters (2..8)
- W, 4, operand width; product width is 2W
- LAT, 2, multiplier latency in clock edges (≥1), operands driven on mul_a/mul_b to matching mul_out
- IDW, derived, clog2(N), requester ID width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N  requester i has operands
- req_ready  out  N  requester i granted this cycle
- req_a  in  N*W  operand A, requester i at [i*W +: W]
- req_b  in  N*W  operand B, same packing
- rsp_valid  out  1  one-cycle pulse, product available
- rsp_id  out  IDW  requester owning rsp_data
- rsp_data  out  2W  unsigned product
- busy  out  N  requester i has an operation in flight
- mul_a  out  W  operand A to multiplier (registered)
- mul_b  out  W  operand B to multiplier (registered)
- mul_out  in  2W  multiplier result

## Operation
- Eligible(i) = req_valid[i] & ~busy[i]. The combinational round-robin picks the first eligible index at or after ptr, wrapping modulo N. req_ready is one-hot or zero.
- Transfer: req_valid[i] & req_ready[i] at a rising edge. On that edge:
  - mul_a/mul_b load requester i's operands.
  - tag stage 0 loads {1, i}.
  - busy[i] sets.
  - ptr loads (i+1) mod N.
- No transfer: tag stage 0 loads valid=0. mul_a/mul_b hold their values. ptr holds.
- Tag pipeline: LAT+1 stages, {valid, id}, shifting every cycle unconditionally.
- Completion: when the final tag stage is valid, rsp_valid, rsp_id and rsp_data (from mul_out) are registered on the next edge. busy[id] clears on that same edge.
- A requester whose busy bit just cleared is eligible in the rsp_valid cycle.
- Products are unsigned, full 2W width, with no truncation. The block does not recompute or check them.
- Responses are returned in issue order; there is no reordering.
- There is no response backpressure: the consumer must take rsp_* in the pulse cycle.

## Timing
- Reset (async assert, synchronous use after deassert) forces to 0: req_ready, rsp_valid, rsp_id, rsp_data, busy, mul_a, mul_b, ptr, and all tag stages.
- Latency: transfer at edge k → mul_a/mul_b valid after edge k → mul_out valid after edge k+LAT → rsp_valid high for exactly the cycle after edge k+LAT+1.
- Throughput: one issue per cycle aggregate. Per requester, one issue per LAT+2 cycles at best.
- busy[i] and req_ready[i] are never both high.
- Simultaneous completion of requester i and a new eligible req_valid[i] in the same cycle: busy[i] clears at the completion edge, and the new transfer can occur in the following (rsp_valid) cycle, not earlier.
- Reset mid-operation: all in-flight tags are discarded and no rsp_valid is produced for them. Any stale mul_out is ignored.
- Requester dropping req_valid before the handshake: no transfer and no state change.
- All requesters valid and idle: grants proceed ptr, ptr+1, … in consecutive cycles, with wrap N-1 → 0.

## Test plan
- The bench multiplier is a behavioral LAT-edge unsigned model, or `pipeline_mul` with rst_n = ~rst and LAT set to its latency.
- Reset: hold rst high with random req_valid → all outputs 0, req_ready 0. Release → first grant goes to the lowest valid index.
- Single op: requester 0, a=4'hA, b=4'hA, LAT=2 → req_ready[0] high one cycle, rsp_valid exactly 3 cycles after the transfer edge, rsp_id=0, rsp_data=8'h64, busy[0] high in between.
- Full contention: all 4 valid, a=i+1, b=4'hF → grants 0,1,2,3 on consecutive cycles. Four back-to-back rsp_valid pulses with ids 0..3 and data 8'h0F, 8'h1E, 8'h2D, 8'h3C.
- Busy block: requester 2 holds req_valid high continuously with a=3, b=5 → req_ready[2] low while busy[2]. The next transfer happens in the rsp_valid cycle. Period is LAT+2 cycles, with data 8'h0F each time.
- Reset mid-flight: requester 1 issues a=4'hD, b=4'h8, then rst is pulsed 1 cycle later → no rsp_valid and busy cleared. A reissue after release gives rsp_id=1, rsp_data=8'h68.
- Fairness: requesters 1 and 3 are continuously valid and ptr starts at 2 → first grant 3, then 1. Grants alternate, with no index granted twice while the other is eligible.
